// File: rtl/prog_mem_pkg.sv
// rtl/prog_mem_pkg.sv - shared state encoding and defaults for the program memory
package prog_mem_pkg;

  // Loader state machine encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Word handed to the core while stalled or when fetching past the array
  localparam int NOP_WORD_DEFAULT = 0;

endpackage

// File: rtl/prog_mem_array.sv
// rtl/prog_mem_array.sv - DEPTH x DATA_W storage, sync write port, async read port
module prog_mem_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  // Index width matches the array so small DEPTH values still slice cleanly
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [IDX_W-1:0]  w_widx;
  logic [IDX_W-1:0]  w_ridx;

  assign w_widx = i_waddr[IDX_W-1:0];
  assign w_ridx = i_raddr[IDX_W-1:0];

  // Write port: contents are deliberately not reset
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[w_widx] <= i_wdata;
    end
  end

  // Read port: out-of-range addresses read as zero, the top substitutes NOP
  always_comb begin
    o_rdata = '0;
    if (32'(i_raddr) < DEPTH) begin
      o_rdata = r_mem[w_ridx];
    end
  end

endmodule

// File: rtl/prog_mem.sv
// rtl/prog_mem.sv - instruction memory with streaming program loader and checksum
module prog_mem
  import prog_mem_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 1 << ADDR_W,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_stall,
  input  logic              i_ld_start,
  input  logic [ADDR_W:0]   i_ld_len,
  input  logic              i_ld_valid,
  input  logic [DATA_W-1:0] i_ld_data,
  output logic              o_ld_ready,
  output logic              o_ld_busy,
  output logic              o_ld_done,
  output logic [DATA_W-1:0] o_ld_sum
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W + 1)'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W:0]   r_remaining;
  logic [DATA_W-1:0] r_sum;
  logic [ADDR_W:0]   w_len_clamped;
  logic              w_accept;
  logic              w_busy;
  logic              w_start;
  logic [DATA_W-1:0] w_arr_rdata;

  assign w_len_clamped = (i_ld_len > DEPTH_L) ? DEPTH_L : i_ld_len;
  assign w_busy        = (r_state != ST_IDLE);
  assign w_start       = (r_state == ST_IDLE) && i_ld_start;

  // Next-state and registered-state decoded outputs
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    o_ld_ready  = 1'b0;
    o_ld_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_ld_start) begin
          w_state_nxt = (w_len_clamped == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        o_ld_ready = 1'b1;
        w_accept   = i_ld_valid;
        if (i_ld_valid && (r_remaining == ONE_L)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        o_ld_done   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register plus write pointer, word counter and running checksum
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_wptr      <= '0;
      r_remaining <= '0;
      r_sum       <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_remaining <= w_len_clamped;
        r_wptr      <= '0;
        r_sum       <= '0;
      end else if (w_accept) begin
        r_remaining <= r_remaining - ONE_L;
        r_wptr      <= r_wptr + 1'b1;
        r_sum       <= r_sum + i_ld_data;
      end
    end
  end

  prog_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .i_clk   (i_clock),
    .i_we    (w_accept && !i_reset),
    .i_waddr (r_wptr),
    .i_wdata (i_ld_data),
    .i_raddr (i_cpu_addr),
    .o_rdata (w_arr_rdata)
  );

  assign o_cpu_stall = w_busy;
  assign o_ld_busy   = w_busy;
  assign o_ld_sum    = r_sum;
  assign o_cpu_rdata = (w_busy || (32'(i_cpu_addr) >= DEPTH)) ? NOP_WORD : w_arr_rdata;

endmodule

// File: tb/tb_prog_mem.sv
// tb/tb_prog_mem.sv - directed scoreboard bench for prog_mem
module tb_prog_mem;

  localparam logic [7:0] NOP = 8'hEA;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_rdata;
  logic       cpu_stall;
  logic       ld_start;
  logic [8:0] ld_len;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       ld_busy;
  logic       ld_done;
  logic [7:0] ld_sum;

  logic [7:0] cpu_addr2;
  logic [7:0] cpu_rdata2;
  logic       cpu_stall2;
  logic       ld_start2;
  logic [8:0] ld_len2;
  logic       ld_valid2;
  logic [7:0] ld_data2;
  logic       ld_ready2;
  logic       ld_busy2;
  logic       ld_done2;
  logic [7:0] ld_sum2;

  always #5 clk = ~clk;

  prog_mem #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .NOP_WORD(NOP)) dut (
    .i_clock(clk), .i_reset(rst), .i_cpu_addr(cpu_addr), .o_cpu_rdata(cpu_rdata),
    .o_cpu_stall(cpu_stall), .i_ld_start(ld_start), .i_ld_len(ld_len),
    .i_ld_valid(ld_valid), .i_ld_data(ld_data), .o_ld_ready(ld_ready),
    .o_ld_busy(ld_busy), .o_ld_done(ld_done), .o_ld_sum(ld_sum)
  );

  prog_mem #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .NOP_WORD(NOP)) dut200 (
    .i_clock(clk), .i_reset(rst), .i_cpu_addr(cpu_addr2), .o_cpu_rdata(cpu_rdata2),
    .o_cpu_stall(cpu_stall2), .i_ld_start(ld_start2), .i_ld_len(ld_len2),
    .i_ld_valid(ld_valid2), .i_ld_data(ld_data2), .o_ld_ready(ld_ready2),
    .o_ld_busy(ld_busy2), .o_ld_done(ld_done2), .o_ld_sum(ld_sum2)
  );

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  int         n_vec = 0;
  int         n_err = 0;
  wr_t        sb_q[$];
  logic [7:0] ld_words[$];
  logic [7:0] model_mem[256];
  bit         model_known[256];
  logic [7:0] exp_sum;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " stall"}, 32'(cpu_stall), 32'd0);
    chk({tag, " busy"},  32'(ld_busy),   32'd0);
    chk({tag, " ready"}, 32'(ld_ready),  32'd0);
    chk({tag, " done"},  32'(ld_done),   32'd0);
  endtask

  task automatic drain_scoreboard(input string tag);
    wr_t w;
    while (sb_q.size() > 0) begin
      w = sb_q.pop_front();
      model_mem[w.addr]   = w.data;
      model_known[w.addr] = 1'b1;
      cpu_addr = w.addr;
      #1;
      chk({tag, " rd"}, 32'(cpu_rdata), 32'(w.data));
    end
  endtask

  task automatic check_model(input string tag, input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      if (model_known[a]) begin
        cpu_addr = 8'(a);
        #1;
        chk({tag, " mem"}, 32'(cpu_rdata), 32'(model_mem[a]));
      end
    end
  endtask

  // Runs a whole load from ld_words; valid either held or toggled, optional stray ld_start
  task automatic do_load(input string tag, input int len, input bit toggle, input bit poke);
    int n;
    int idx;
    int cyc;
    bit v;
    n = (len > 256) ? 256 : len;
    exp_sum  = 8'h00;
    cpu_addr = 8'h00;
    ld_start = 1'b1;
    ld_len   = 9'(len);
    ld_valid = 1'b0;
    tick();
    ld_start = 1'b0;
    idx = 0;
    cyc = 1;
    while (1) begin
      chk({tag, " stall"}, 32'(cpu_stall), 32'd1);
      chk({tag, " nop"},   32'(cpu_rdata), 32'(NOP));
      chk({tag, " ready"}, 32'(ld_ready),  32'(idx < n));
      chk({tag, " done"},  32'(ld_done),   32'(idx == n));
      if (idx == n) break;
      if (cyc > 2000) begin
        chk({tag, " cycle budget"}, 32'(cyc), 32'(n + 1));
        break;
      end
      v = toggle ? !cyc[0] : 1'b1;
      if (poke && cyc == 2) begin
        ld_start = 1'b1;
        ld_len   = 9'd1;
      end else begin
        ld_start = 1'b0;
      end
      ld_valid = v;
      if (v) begin
        ld_data = ld_words[idx];
        sb_q.push_back('{addr: 8'(idx), data: ld_words[idx]});
        exp_sum += ld_words[idx];
        idx++;
      end
      tick();
      cyc++;
    end
    ld_start = 1'b0;
    if (!toggle) chk({tag, " done cycle"}, 32'(cyc), 32'(n + 1));
    chk({tag, " sum at done"}, 32'(ld_sum), 32'(exp_sum));
    ld_data = 8'h99;
    tick();
    check_idle({tag, " after"});
    chk({tag, " sum hold"}, 32'(ld_sum), 32'(exp_sum));
    tick();
    chk({tag, " ready stays low"}, 32'(ld_ready), 32'd0);
    ld_valid = 1'b0;
    drain_scoreboard(tag);
  endtask

  initial begin
    rst = 1'b1; cpu_addr = '0; ld_start = 0; ld_len = '0; ld_valid = 0; ld_data = '0;
    cpu_addr2 = '0; ld_start2 = 0; ld_len2 = '0; ld_valid2 = 0; ld_data2 = '0;
    for (int i = 0; i < 256; i++) model_known[i] = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_idle("reset");
    chk("reset sum", 32'(ld_sum), 32'd0);

    cpu_addr2 = 8'd200;
    #1;
    chk("d200 addr200", 32'(cpu_rdata2), 32'(NOP));
    cpu_addr2 = 8'd255;
    #1;
    chk("d200 addr255", 32'(cpu_rdata2), 32'(NOP));
    chk("d200 stall", 32'(cpu_stall2), 32'd0);

    ld_words = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
    do_load("pre8", 8, 1'b0, 1'b0);

    ld_words = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_load("load4", 4, 1'b0, 1'b0);
    chk("load4 sum AA", 32'(ld_sum), 32'hAA);
    check_model("load4", 0, 7);

    ld_words = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_load("toggle4", 4, 1'b1, 1'b0);
    chk("toggle4 sum AA", 32'(ld_sum), 32'hAA);
    check_model("toggle4", 0, 7);

    ld_words = '{};
    do_load("len0", 0, 1'b0, 1'b0);
    chk("len0 sum", 32'(ld_sum), 32'd0);
    check_model("len0", 0, 7);

    ld_words = '{8'hFF, 8'hFF, 8'h03};
    do_load("wrap", 3, 1'b0, 1'b0);
    chk("wrap sum 01", 32'(ld_sum), 32'h01);

    ld_words = '{8'h05, 8'h06, 8'h07, 8'h08};
    do_load("poke", 4, 1'b0, 1'b1);

    ld_start = 1'b1; ld_len = 9'd4; ld_valid = 1'b0;
    tick();
    ld_start = 1'b0; ld_valid = 1'b1; ld_data = 8'hC1;
    tick();
    ld_data = 8'hC2;
    tick();
    chk("abort mid busy", 32'(ld_busy), 32'd1);
    rst = 1'b1; ld_valid = 1'b0;
    tick();
    rst = 1'b0;
    check_idle("abort");
    chk("abort sum", 32'(ld_sum), 32'd0);
    tick();
    chk("abort no done", 32'(ld_done), 32'd0);
    model_mem[0] = 8'hC1;
    model_mem[1] = 8'hC2;
    check_model("abort", 0, 3);

    ld_words = '{};
    for (int i = 0; i < 300; i++) ld_words.push_back(8'((i * 37 + 5) & 255));
    do_load("clamp300", 300, 1'b0, 1'b0);
    check_model("clamp300", 0, 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
